// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample to BCD conversion path.
package adc_pkg;

    localparam int ADC_WIDTH  = 12;
    localparam int BCD_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/adc_dato_bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any BCD digit of 5 or more.
module bcd_add3
    import adc_pkg::*;
(
    input  logic [3:0] in_i,
    output logic [3:0] out_o
);

    assign out_o = (in_i >= BCD_ADJ_THRESH) ? (in_i + BCD_ADJ_ADD) : in_i;

endmodule

// File: rtl/adc_dato_bcd.sv
// Captures an ADC sample on the rising edge of done and converts it to packed
// BCD with a sequential shift-add-3 engine; result is flagged by bcd_valid.
module adc_dato_bcd
    import adc_pkg::*;
#(
    parameter int WIDTH  = ADC_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  Clock_Nexys,
    input  logic                  Reset,
    input  logic                  done,
    input  logic [WIDTH-1:0]      Dato,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int BW    = 4 * DIGITS;
    localparam int SW    = BW + WIDTH;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [SW-1:0]      sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               done_prev_q;

    logic               start;
    logic [SW-1:0]      step_src;
    logic [BW-1:0]      adj;
    logic [SW-1:0]      step_out;

    assign start = done & ~done_prev_q;

    // LOAD feeds the fresh sample straight into the first shift step, so the
    // twelve shifts finish in time for the result to land one cycle after.
    assign step_src = (state_q == LOAD) ? {{BW{1'b0}}, Dato} : sreg_q;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_add3 u_add3 (
                .in_i  (step_src[WIDTH + 4*gi +: 4]),
                .out_o (adj[4*gi +: 4])
            );
        end
    endgenerate

    assign step_out = {adj[BW-2:0], step_src[WIDTH-1:0], 1'b0};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q | (start & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                sreg_d  = step_out;
                cnt_d   = CNT_W'(1);
                state_d = SHIFT;
            end
            SHIFT: begin
                sreg_d = step_out;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                bcd_d   = sreg_q[SW-1 -: BW];
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock_Nexys) begin
        if (Reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            done_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            done_prev_q <= done;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_adc_dato_bcd.sv
// Directed bench for adc_dato_bcd with a cycle-level reference model.
module tb_adc_dato_bcd;

    logic        clk;
    logic        Reset;
    logic        done;
    logic [11:0] Dato;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;

    adc_dato_bcd dut (
        .Clock_Nexys (clk),
        .Reset       (Reset),
        .done        (done),
        .Dato        (Dato),
        .bcd         (bcd),
        .bcd_valid   (bcd_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = 16'((((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
                     (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    // Model: a conversion is an age counter; the result appears 13 edges after start.
    initial begin
        logic        r, d, m_prev, m_valid, m_ovr, st, busy_before;
        logic [11:0] x;
        logic [15:0] m_bcd;
        int          m_age, m_sample;
        m_prev = 1'b1; m_valid = 1'b0; m_ovr = 1'b0; m_bcd = '0;
        m_age = -1; m_sample = 0;
        forever begin
            @(posedge clk);
            r = Reset; d = done; x = Dato;
            #1;
            if (r) begin
                m_prev = 1'b1; m_valid = 1'b0; m_ovr = 1'b0; m_bcd = '0; m_age = -1;
            end else begin
                st = d & ~m_prev;
                m_prev = d;
                m_valid = 1'b0;
                busy_before = (m_age >= 0);
                if (m_age >= 0) begin
                    m_age++;
                    if (m_age == 13) begin
                        m_bcd = to_bcd(m_sample);
                        m_valid = 1'b1;
                        m_age = -1;
                    end
                end
                if (st) begin
                    if (busy_before) m_ovr = 1'b1;
                    else begin
                        m_age = 0;
                        m_sample = int'(x);
                    end
                end
            end
            check("bcd", 32'(bcd), 32'(m_bcd));
            check("bcd_valid", 32'(bcd_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_age >= 0));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (bcd_valid === 1'b1) valid_cnt++;
        end
    end

    task automatic conv(input logic [11:0] d, input logic [15:0] exp, input string name);
        int v0;
        v0 = valid_cnt;
        @(negedge clk); Dato = d; done = 1'b1;
        repeat (2) @(negedge clk);
        done = 1'b0;
        repeat (14) @(negedge clk);
        check(name, 32'(bcd), 32'(exp));
        check({name, "_pulses"}, 32'(valid_cnt - v0), 32'd1);
        $display("conv Dato=%0d bcd=%h", d, bcd);
    endtask

    initial begin
        int v0;
        Reset = 1'b1; done = 1'b0; Dato = '0;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        check("reset_valid", 32'(bcd_valid), 32'h0);

        conv(12'b101010101010, 16'h2730, "bcd_2730");
        conv(12'b010101010101, 16'h1365, "bcd_1365");
        conv(12'hFFF, 16'h4095, "bcd_4095");
        conv(12'd0, 16'h0000, "bcd_0");
        conv(12'd999, 16'h0999, "bcd_999");

        // done held high for a long time: one conversion only
        v0 = valid_cnt;
        @(negedge clk); Dato = 12'd1234; done = 1'b1;
        repeat (50) @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        check("held_pulses", 32'(valid_cnt - v0), 32'd1);
        check("held_bcd", 32'(bcd), 32'h1234);
        $display("held done bcd=%h", bcd);

        // done already high when reset releases: no conversion
        v0 = valid_cnt;
        Reset = 1'b1; done = 1'b1; Dato = 12'd77;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        repeat (20) @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        check("relrst_pulses", 32'(valid_cnt - v0), 32'd0);
        check("relrst_bcd", 32'(bcd), 32'h0);
        $display("done through reset release bcd=%h", bcd);

        // second edge 5 cycles after the first: overrun, first result intact
        v0 = valid_cnt;
        Dato = 12'd2730; done = 1'b1;
        repeat (2) @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        done = 1'b1;
        repeat (2) @(negedge clk);
        done = 1'b0;
        repeat (14) @(negedge clk);
        check("ovr_bcd", 32'(bcd), 32'h2730);
        check("ovr_pulses", 32'(valid_cnt - v0), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        repeat (5) @(negedge clk);
        check("ovr_sticky", 32'(overrun), 32'd1);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        $display("overrun test bcd=%h", bcd);

        // reset in the middle of a conversion
        v0 = valid_cnt;
        @(negedge clk); Dato = 12'd2730; done = 1'b1;
        repeat (2) @(negedge clk);
        done = 1'b0;
        repeat (4) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check("midrst_bcd", 32'(bcd), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        repeat (15) @(negedge clk);
        check("midrst_pulses", 32'(valid_cnt - v0), 32'd0);
        $display("mid-conversion reset bcd=%h", bcd);
        conv(12'd1365, 16'h1365, "after_rst_1365");

        // back-to-back starts 14 cycles apart
        v0 = valid_cnt;
        @(negedge clk); Dato = 12'd2730; done = 1'b1;
        repeat (2) @(negedge clk);
        done = 1'b0;
        repeat (12) @(negedge clk);
        Dato = 12'd1365; done = 1'b1;
        repeat (2) @(negedge clk);
        done = 1'b0;
        repeat (16) @(negedge clk);
        check("b2b_bcd", 32'(bcd), 32'h1365);
        check("b2b_pulses", 32'(valid_cnt - v0), 32'd2);
        check("b2b_overrun", 32'(overrun), 32'd0);
        $display("back-to-back bcd=%h", bcd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
